// File: rtl/rs_job_scheduler_if.sv
// rs_job_scheduler_if -- bundle of the job request, RS command, RS completion
// and status channels of rs_job_scheduler.
//   slave  : scheduler side (rs_job_scheduler)
//   master : environment side (HPS bridge / RS controller / status consumer)
// Signals:
//   req_valid_i/req_ready_o/req_en_decn_i/req_addr_i : job request handshake
//   flush_i                                          : drop queued jobs
//   rs_exec_o/rs_en_decn_o/rs_addr_o                 : command to RS controller
//   encode_done_i/decode_done_i/dec_cerr_i/dec_ncerr_i : completion from controller
//   sts_valid_o/sts_ready_i/sts_o                    : status record handshake
//   q_level_o/busy_o                                 : queue level, FSM busy
interface rs_job_scheduler_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 8
);
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic                     req_en_decn_i;
  logic [ADDR_W-1:0]        req_addr_i;
  logic                     flush_i;
  logic                     rs_exec_o;
  logic                     rs_en_decn_o;
  logic [ADDR_W-1:0]        rs_addr_o;
  logic                     encode_done_i;
  logic                     decode_done_i;
  logic                     dec_cerr_i;
  logic                     dec_ncerr_i;
  logic                     sts_valid_o;
  logic                     sts_ready_i;
  logic [ADDR_W+3:0]        sts_o;
  logic [$clog2(DEPTH):0]   q_level_o;
  logic                     busy_o;

  modport slave (
    input  req_valid_i, req_en_decn_i, req_addr_i, flush_i,
    input  encode_done_i, decode_done_i, dec_cerr_i, dec_ncerr_i, sts_ready_i,
    output req_ready_o, rs_exec_o, rs_en_decn_o, rs_addr_o,
    output sts_valid_o, sts_o, q_level_o, busy_o
  );

  modport master (
    output req_valid_i, req_en_decn_i, req_addr_i, flush_i,
    output encode_done_i, decode_done_i, dec_cerr_i, dec_ncerr_i, sts_ready_i,
    input  req_ready_o, rs_exec_o, rs_en_decn_o, rs_addr_o,
    input  sts_valid_o, sts_o, q_level_o, busy_o
  );
endinterface

// File: rtl/rs_job_scheduler.sv
// rs_job_scheduler -- job queue and sequencer in front of the RS controller
// command port. Buffers encode/decode jobs in a circular FIFO, issues them one
// at a time as a single-cycle exec pulse, waits for the matching done strobe
// and returns a status record {addr, en_decn, cerr, ncerr, timeout}.
// Ports:
//   clk_i   : single clock
//   rst_n_i : asynchronous active-low reset
//   bus     : rs_job_scheduler_if.slave (request, command, completion, status)
// Parameters: DEPTH (power of two, >= 2), ADDR_W, TIMEOUT_CYCLES.
// Optional macro RS_SCHED_TIMEOUT_EN: builds the WAIT watchdog; when undefined
// WAIT waits indefinitely and the timeout bit is always 0.
module rs_job_scheduler #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  rs_job_scheduler_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPORT} state_t;

  logic [ADDR_W:0]    r_mem [DEPTH];  // {en_decn, addr}
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;

  state_t             r_state;
  logic               r_exec;
  logic               r_en_decn;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_sts_valid;
  logic [ADDR_W+3:0]  r_sts;
  logic               r_busy;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_done;
  logic w_expired;

  // Full is taken from the registered level, so a pop in the same cycle never
  // makes room for a push.
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = bus.req_valid_i && !w_full && !bus.flush_i;
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !bus.flush_i;
  assign w_done  = r_en_decn ? bus.encode_done_i : bus.decode_done_i;

  // Queue pointers and level
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (bus.flush_i) begin
      r_rd_ptr <= r_wr_ptr;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read below r_level.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.req_en_decn_i, bus.req_addr_i};
  end

`ifdef RS_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] r_wd;

  // Cleared in ISSUE so it reads 0 in the first WAIT cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wd <= '0;
    end else if (r_state == S_ISSUE) begin
      r_wd <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  assign w_expired = (r_state == S_WAIT) && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_expired        = 1'b0;
`endif

  // Sequencer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_exec      <= 1'b0;
      r_en_decn   <= 1'b0;
      r_addr      <= '0;
      r_sts_valid <= 1'b0;
      r_sts       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_exec <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_en_decn, r_addr} <= r_mem[r_rd_ptr];
            r_exec              <= 1'b1;
            r_busy              <= 1'b1;
            r_state             <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A matching done wins over watchdog expiry in the same cycle.
          if (w_done) begin
            r_sts       <= {r_addr, r_en_decn,
                            !r_en_decn && bus.dec_cerr_i,
                            !r_en_decn && bus.dec_ncerr_i, 1'b0};
            r_sts_valid <= 1'b1;
            r_state     <= S_REPORT;
          end else if (w_expired) begin
            r_sts       <= {r_addr, r_en_decn, 3'b001};
            r_sts_valid <= 1'b1;
            r_state     <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (bus.sts_ready_i) begin
            r_sts_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = !w_full && !bus.flush_i;
  assign bus.rs_exec_o    = r_exec;
  assign bus.rs_en_decn_o = r_en_decn;
  assign bus.rs_addr_o    = r_addr;
  assign bus.sts_valid_o  = r_sts_valid;
  assign bus.sts_o        = r_sts;
  assign bus.q_level_o    = r_level;
  assign bus.busy_o       = r_busy;
endmodule

// File: tb/tb_rs_job_scheduler.sv
// tb_rs_job_scheduler -- self-checking bench for rs_job_scheduler.
// Table of single jobs with hand-computed status records, hand-written
// sequences for fill/wrap, flush, status back-pressure, reset and watchdog,
// then a randomized phase checked against a transaction-level queue model.
module tb_rs_job_scheduler;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TO     = 16;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  rs_job_scheduler_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus();

  rs_job_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  typedef struct {
    logic        en;
    logic [7:0]  addr;
    logic        cerr;
    logic        ncerr;
    logic [11:0] exp_sts;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic clr_inputs();
    bus.req_valid_i   = 1'b0;
    bus.req_en_decn_i = 1'b0;
    bus.req_addr_i    = '0;
    bus.flush_i       = 1'b0;
    bus.encode_done_i = 1'b0;
    bus.decode_done_i = 1'b0;
    bus.dec_cerr_i    = 1'b0;
    bus.dec_ncerr_i   = 1'b0;
    bus.sts_ready_i   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_exec"},  bus.rs_exec_o,    1'b0);
    chk({tag, "_en"},    bus.rs_en_decn_o, 1'b0);
    chk({tag, "_addr"},  bus.rs_addr_o,    '0);
    chk({tag, "_sv"},    bus.sts_valid_o,  1'b0);
    chk({tag, "_sts"},   bus.sts_o,        '0);
    chk({tag, "_lvl"},   bus.q_level_o,    '0);
    chk({tag, "_busy"},  bus.busy_o,       1'b0);
    chk({tag, "_ready"}, bus.req_ready_o,  1'b1);
  endtask

  task automatic push1(input logic en, input logic [7:0] addr);
    bus.req_valid_i   = 1'b1;
    bus.req_en_decn_i = en;
    bus.req_addr_i    = addr;
    tick();
    bus.req_valid_i   = 1'b0;
  endtask

  task automatic wait_exec(input int unsigned max_cyc, input string name);
    int unsigned n = 0;
    while (!bus.rs_exec_o && n < max_cyc) begin
      tick();
      n++;
    end
    chk(name, bus.rs_exec_o, 1'b1);
  endtask

  // Caller must be in WAIT (at least one edge after the exec pulse ended).
  task automatic finish_job(input logic en, input logic cerr, input logic ncerr,
                            input logic [11:0] exp);
    if (en) bus.encode_done_i = 1'b1;
    else    bus.decode_done_i = 1'b1;
    bus.dec_cerr_i  = cerr;
    bus.dec_ncerr_i = ncerr;
    tick();
    bus.encode_done_i = 1'b0;
    bus.decode_done_i = 1'b0;
    bus.dec_cerr_i    = 1'b0;
    bus.dec_ncerr_i   = 1'b0;
    chk("fin_sv", bus.sts_valid_o, 1'b1);
    chk("fin_sts", bus.sts_o, exp);
    bus.sts_ready_i = 1'b1;
    tick();
    bus.sts_ready_i = 1'b0;
    chk("fin_sv_clr", bus.sts_valid_o, 1'b0);
    chk("fin_busy_clr", bus.busy_o, 1'b0);
  endtask

  // One job from idle/empty with full latency and handshake checks.
  task automatic run_job(input vec_t v);
    push1(v.en, v.addr);
    chk("job_exec_e0", bus.rs_exec_o, 1'b0);
    chk("job_lvl_e0", bus.q_level_o, 1);
    tick();
    chk("job_exec_e1", bus.rs_exec_o, 1'b1);
    chk("job_lvl_e1", bus.q_level_o, 0);
    chk("job_cmd", {bus.rs_en_decn_o, bus.rs_addr_o}, {v.en, v.addr});
    tick();
    chk("job_exec_e2", bus.rs_exec_o, 1'b0);
    chk("job_busy", bus.busy_o, 1'b1);
    // non-matching strobe while in WAIT
    if (v.en) begin bus.decode_done_i = 1'b1; bus.dec_ncerr_i = 1'b1; end
    else      bus.encode_done_i = 1'b1;
    tick();
    clr_inputs();
    chk("job_stray", bus.sts_valid_o, 1'b0);
    if (v.en) bus.encode_done_i = 1'b1;
    else      bus.decode_done_i = 1'b1;
    bus.dec_cerr_i  = v.cerr;
    bus.dec_ncerr_i = v.ncerr;
    tick();
    clr_inputs();
    for (int k = 0; k < 3; k++) begin
      chk("job_sv_hold", bus.sts_valid_o, 1'b1);
      chk("job_sts", bus.sts_o, v.exp_sts);
      chk("job_cmd_hold", {bus.rs_en_decn_o, bus.rs_addr_o}, {v.en, v.addr});
      if (k < 2) tick();
    end
    bus.sts_ready_i = 1'b1;
    tick();
    bus.sts_ready_i = 1'b0;
    chk("job_sv_clr", bus.sts_valid_o, 1'b0);
    chk("job_busy_clr", bus.busy_o, 1'b0);
  endtask

  task automatic random_phase(input int unsigned ncyc);
    logic [ADDR_W:0]   q[$];
    logic [ADDR_W:0]   cur = '0;
    logic              inflight = 1'b0;
    logic              pend = 1'b0;
    logic              done_sent = 1'b0;
    logic              first = 1'b0;
    logic              exp_exec = 1'b0;
    logic              exp_exec_n;
    logic [11:0]       rec = '0;
    int unsigned       dly = 0;
    for (int unsigned c = 0; c < ncyc; c++) begin
      // observe state after the previous edge
      chk("rnd_exec", bus.rs_exec_o, exp_exec);
      if (exp_exec) begin
        cur       = q.pop_front();
        inflight  = 1'b1;
        done_sent = 1'b0;
        first     = 1'b1;
        dly       = $urandom_range(1, 6);
      end
      chk("rnd_lvl", bus.q_level_o, q.size());
      chk("rnd_busy", bus.busy_o, inflight);
      chk("rnd_sv", bus.sts_valid_o, pend);
      if (pend) chk("rnd_sts", bus.sts_o, rec);
      if (inflight) chk("rnd_cmd", {bus.rs_en_decn_o, bus.rs_addr_o}, cur);
      // drive the next cycle
      bus.flush_i       = ($urandom_range(0, 15) == 0);
      bus.req_valid_i   = $urandom_range(0, 1) != 0;
      bus.req_en_decn_i = $urandom_range(0, 1) != 0;
      bus.req_addr_i    = 8'($urandom);
      bus.sts_ready_i   = $urandom_range(0, 2) != 0;
      bus.dec_cerr_i    = $urandom_range(0, 1) != 0;
      bus.dec_ncerr_i   = $urandom_range(0, 1) != 0;
      bus.encode_done_i = 1'b0;
      bus.decode_done_i = 1'b0;
      exp_exec_n = !inflight && (q.size() > 0) && !bus.flush_i;
      if (pend && bus.sts_ready_i) begin
        pend     = 1'b0;
        inflight = 1'b0;
      end
      if (inflight && !first && !done_sent) begin
        if (dly == 1) begin
          if (cur[ADDR_W]) bus.encode_done_i = 1'b1;
          else             bus.decode_done_i = 1'b1;
          done_sent = 1'b1;
          pend      = 1'b1;
          rec = {cur[ADDR_W-1:0], cur[ADDR_W],
                 !cur[ADDR_W] && bus.dec_cerr_i, !cur[ADDR_W] && bus.dec_ncerr_i, 1'b0};
        end else begin
          dly--;
          if ($urandom_range(0, 3) == 0) begin
            if (cur[ADDR_W]) bus.decode_done_i = 1'b1;
            else             bus.encode_done_i = 1'b1;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        // outside WAIT any strobe must be ignored
        bus.encode_done_i = $urandom_range(0, 1) != 0;
        bus.decode_done_i = $urandom_range(0, 1) != 0;
      end
      first = 1'b0;
      #1;
      chk("rnd_ready", bus.req_ready_o, (q.size() < DEPTH) && !bus.flush_i);
      if (bus.flush_i) q.delete();
      else if (bus.req_valid_i && q.size() < DEPTH) q.push_back({bus.req_en_decn_i, bus.req_addr_i});
      exp_exec = exp_exec_n;
      tick();
    end
    clr_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tbl[0] = '{en: 1'b1, addr: 8'h04, cerr: 1'b0, ncerr: 1'b0, exp_sts: 12'h048};
    tbl[1] = '{en: 1'b0, addr: 8'h08, cerr: 1'b0, ncerr: 1'b1, exp_sts: 12'h082};
    tbl[2] = '{en: 1'b0, addr: 8'hA5, cerr: 1'b1, ncerr: 1'b0, exp_sts: 12'hA54};
    tbl[3] = '{en: 1'b1, addr: 8'hFF, cerr: 1'b1, ncerr: 1'b1, exp_sts: 12'hFF8};
    tbl[4] = '{en: 1'b0, addr: 8'h00, cerr: 1'b1, ncerr: 1'b1, exp_sts: 12'h006};
    tbl[5] = '{en: 1'b0, addr: 8'h3C, cerr: 1'b0, ncerr: 1'b0, exp_sts: 12'h3C0};

    clr_inputs();
    rst_n_i = 1'b0;
    tick();
    tick();
    chk_all_zero("rst");
    rst_n_i = 1'b1;
    tick();
    chk_all_zero("post_rst");

    for (int i = 0; i < 6; i++) run_job(tbl[i]);

    // Fill past DEPTH while the head job is stalled, twice for wrap-around.
    for (int r = 0; r < 2; r++) begin
      push1(1'b1, 8'(8'h10 + r));
      wait_exec(4, "fill_head_exec");
      tick();
      bus.req_valid_i = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
        bus.req_en_decn_i = (i % 2) != 0;
        bus.req_addr_i    = 8'(8'h20 + 8'h40 * r + i);
        #1;
        chk("fill_ready", bus.req_ready_o, i < DEPTH);
        tick();
      end
      bus.req_valid_i = 1'b0;
      chk("fill_lvl", bus.q_level_o, DEPTH);
      chk("fill_ready_full", bus.req_ready_o, 1'b0);
      finish_job(1'b1, 1'b0, 1'b0, {8'(8'h10 + r), 1'b1, 3'b000});
      for (int i = 0; i < DEPTH; i++) begin
        logic [7:0] a;
        logic       e;
        a = 8'(8'h20 + 8'h40 * r + i);
        e = (i % 2) != 0;
        wait_exec(4, "fill_issue");
        chk("fill_order", {bus.rs_en_decn_o, bus.rs_addr_o}, {e, a});
        tick();
        finish_job(e, 1'b0, 1'b0, {a, e, 3'b000});
      end
      chk("fill_drained", bus.q_level_o, 0);
    end

    // Flush during WAIT of the first of three jobs, with a push attempt.
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_en_decn_i = 1'b0;
      bus.req_addr_i    = 8'(8'h50 + i);
      tick();
    end
    bus.req_valid_i = 1'b0;
    chk("fl_lvl_pre", bus.q_level_o, 2);
    chk("fl_cmd", {bus.rs_en_decn_o, bus.rs_addr_o}, {1'b0, 8'h50});
    bus.flush_i     = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 8'h99;
    #1;
    chk("fl_ready", bus.req_ready_o, 1'b0);
    tick();
    clr_inputs();
    chk("fl_lvl", bus.q_level_o, 0);
    chk("fl_busy", bus.busy_o, 1'b1);
    finish_job(1'b0, 1'b1, 1'b0, 12'h504);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("fl_idle_busy", bus.busy_o, 1'b0);
      chk("fl_idle_exec", bus.rs_exec_o, 1'b0);
    end

    // Status back-pressure with jobs queued, then reset in WAIT.
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req_en_decn_i = 1'b1;
      bus.req_addr_i    = 8'(8'h70 + i);
      tick();
    end
    bus.req_valid_i   = 1'b0;
    bus.encode_done_i = 1'b1;
    tick();
    bus.encode_done_i = 1'b0;
    chk("bp_sv", bus.sts_valid_o, 1'b1);
    for (int k = 0; k < 50; k++) begin
      tick();
      chk("bp_exec", bus.rs_exec_o, 1'b0);
      chk("bp_sts", bus.sts_o, 12'h708);
      chk("bp_lvl", bus.q_level_o, 2);
    end
    bus.sts_ready_i = 1'b1;
    tick();
    bus.sts_ready_i = 1'b0;
    wait_exec(4, "bp_next_exec");
    chk("bp_next_cmd", {bus.rs_en_decn_o, bus.rs_addr_o}, {1'b1, 8'h71});
    tick();
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    tick();
    rst_n_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_after_busy", bus.busy_o, 1'b0);
      chk("rst_after_sv", bus.sts_valid_o, 1'b0);
      chk("rst_after_exec", bus.rs_exec_o, 1'b0);
    end

`ifdef RS_SCHED_TIMEOUT_EN
    push1(1'b0, 8'h33);
    wait_exec(4, "to_exec");
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("to_sv", bus.sts_valid_o, k == 17);
    end
    chk("to_sts", bus.sts_o, 12'h331);
    bus.sts_ready_i = 1'b1;
    tick();
    bus.sts_ready_i = 1'b0;
    push1(1'b0, 8'h34);
    wait_exec(4, "to2_exec");
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("to2_sv", bus.sts_valid_o, 1'b0);
    end
    finish_job(1'b0, 1'b0, 1'b1, 12'h342);
`else
    push1(1'b1, 8'h35);
    wait_exec(4, "nto_exec");
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("nto_sv", bus.sts_valid_o, 1'b0);
    end
    finish_job(1'b1, 1'b0, 1'b0, 12'h358);
`endif

    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    tick();
    random_phase(3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
